// File: rtl/lab2_fir_out_buffer.sv
// lab2_fir_out_buffer
//   First-word-fall-through output FIFO behind the FIR stage. It absorbs
//   bursts from y_in and hands them to a ready/valid consumer. When the
//   queue is full and the consumer is not taking a sample in the same cycle,
//   the incoming sample is dropped. Every drop is recorded in a sticky
//   overflow flag and in a saturating 8-bit drop counter.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   y_in       FIR output sample
//   y_valid    y_in carries a new sample this cycle
//   flush      synchronous clear of queue contents and statistics
//   out_data   head-of-queue sample (0 when empty)
//   out_valid  out_data holds a valid sample
//   out_ready  consumer takes out_data this cycle
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: at least one sample dropped
//   drop_cnt   number of dropped samples, saturates at 255
module lab2_fir_out_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         y_in,
  input  logic                     y_valid,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // Pointers are AW bits wide, so wrap modulo DEPTH is free for power-of-2 depths.
  assign full = (count_q == CW'(DEPTH));
  assign pop  = out_valid && out_ready;
  // A full queue still accepts a sample when the head leaves in the same cycle.
  assign push = y_valid && (!full || pop);
  assign drop = y_valid && full && !pop;

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Storage is deliberately not reset. Stale words cannot be seen because
  // out_data is forced to 0 while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= y_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lab2_fir_out_buffer.sv
module tb_lab2_fir_out_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] y_in;
  logic             y_valid;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of samples plus drop statistics.
  int unsigned m_q[$];
  bit          m_ovf;
  int          m_drop;

  lab2_fir_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit yv, input int unsigned y, input bit rdy, input bit fl);
    bit was_full;
    bit p;
    if (fl) begin
      model_clear();
    end else begin
      was_full = (m_q.size() == DEPTH);
      p = (m_q.size() > 0) && rdy;
      if (p) void'(m_q.pop_front());
      if (yv && (!was_full || p)) begin
        m_q.push_back(y);
      end else if (yv) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    chk({tag, ".data"},  32'(out_data),  (m_q.size() != 0) ? m_q[0] : 32'd0);
    chk({tag, ".count"}, 32'(count),     32'(m_q.size()));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".drop"},  32'(drop_cnt),  32'(m_drop));
  endtask

  // Drive one cycle of inputs, clock it, update the model, and check #1 after the edge.
  task automatic tick(input bit yv, input int unsigned y, input bit rdy, input bit fl, input string tag);
    y_valid   = yv;
    y_in      = y[WIDTH-1:0];
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    model_step(yv, y & 32'hFFFF, rdy, fl);
    #1;
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; y_valid = 1'b0; y_in = '0; flush = 1'b0; out_ready = 1'b0;
    model_clear();
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.count", 32'(count),     32'd0);
    chk("rst.data",  32'(out_data),  32'd0);
    chk("rst.ovf",   32'(overflow),  32'd0);
    chk("rst.drop",  32'(drop_cnt),  32'd0);
    reset = 1'b0;

    // Single push into an empty queue, visible on the next cycle.
    tick(1, 32'h0011, 0, 0, "p1");
    chk("p1.valid_c", 32'(out_valid), 32'd1);
    chk("p1.data_c",  32'(out_data),  32'h0011);
    chk("p1.count_c", 32'(count),     32'd1);
    tick(0, 0, 0, 1, "fl1");

    // Six pushes into a 4-deep queue with no consumer: two drops.
    for (int i = 1; i <= 6; i++) tick(1, i, 0, 0, "fill6");
    chk("fill6.count_c", 32'(count),    32'd4);
    chk("fill6.ovf_c",   32'(overflow), 32'd1);
    chk("fill6.drop_c",  32'(drop_cnt), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      chk("pop_order", 32'(out_data), 32'(i));
      tick(0, 0, 1, 0, "pop4");
    end
    chk("pop4.count_c", 32'(count), 32'd0);

    // Full queue, push and pop in the same cycle: accepted, no drop.
    tick(0, 0, 0, 1, "fl2");
    for (int i = 0; i < 4; i++) tick(1, 32'h10 + i, 0, 0, "fill4");
    tick(1, 32'h00AA, 1, 0, "fullpp");
    chk("fullpp.count_c", 32'(count),    32'd4);
    chk("fullpp.drop_c",  32'(drop_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("fullpp.last", 32'(out_data), 32'h00AA);
      tick(0, 0, 1, 0, "drain");
    end

    // Drop counter saturation, then flush with y_valid/out_ready also active.
    for (int i = 0; i < 4; i++) tick(1, $urandom, 0, 0, "fill_s");
    for (int i = 0; i < 300; i++) tick(1, $urandom, 0, 0, "sat");
    chk("sat.drop_c", 32'(drop_cnt), 32'd255);
    chk("sat.ovf_c",  32'(overflow), 32'd1);
    tick(1, 32'h5555, 1, 1, "flsat");
    chk("flsat.count_c", 32'(count),     32'd0);
    chk("flsat.drop_c",  32'(drop_cnt),  32'd0);
    chk("flsat.ovf_c",   32'(overflow),  32'd0);
    chk("flsat.valid_c", 32'(out_valid), 32'd0);

    // Reset asserted between edges with three entries queued.
    for (int i = 0; i < 3; i++) tick(1, 32'h70 + i, 0, 0, "fill3");
    y_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.count", 32'(count),     32'd0);
    chk("arst.data",  32'(out_data),  32'd0);
    model_clear();
    #2;
    reset = 1'b0;
    tick(1, 32'h1234, 0, 0, "post_rst");
    chk("post_rst.data_c",  32'(out_data), 32'h1234);
    chk("post_rst.count_c", 32'(count),    32'd1);

    // Streaming: each sample appears the cycle after it is presented.
    tick(0, 0, 0, 1, "fl3");
    for (int i = 0; i < 20; i++) begin
      tick(1, 32'h100 + i, 1, 0, "stream");
      chk("stream.data_c", 32'(out_data), 32'h100 + i);
      chk("stream.cnt_le1", 32'(count <= 3'd1), 32'd1);
    end
    chk("stream.drop_c", 32'(drop_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0,
           ($urandom % 64) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
